// File: rtl/beta_mem_sequencer.sv
// Beta-style instruction sequencer: fetch / execute / memory / commit with a bus-timeout halt.
// Optional interrupt-take logic is compiled in with `define BETA_SEQ_IRQ_EN.
module beta_mem_sequencer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq,
    input  logic        moe,
    input  logic        mwr,
    input  logic [31:0] inst_addr,
    input  logic [31:0] data_addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] inst,
    output logic [31:0] ldata,
    output logic        pc_en,
    output logic        rf_we_en,
    output logic        irq_take,
    output logic        bus_err,
    output logic        halted
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        EXEC   = 3'd1,
        MEM    = 3'd2,
        COMMIT = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] tmo_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic          we_r;
    logic [31:0]   inst_r;
    logic [31:0]   ldata_r;
    logic          req_phase_s;
    logic          first_s;
    logic          wait_s;
    logic          tmo_hit_s;
    logic          stall_s;
    logic [31:0]   addr_s;
    logic [31:0]   wdata_s;
    logic          we_s;

`ifdef BETA_SEQ_IRQ_EN
    logic irq_pend_r;
    logic irq_take_r;
    logic take_s;

    // The interrupt-take cycle sits in FETCH with the request held off.
    assign take_s   = (state_r == COMMIT) && (irq_pend_r || irq);
    assign stall_s  = irq_take_r;
    assign irq_take = irq_take_r && !reset;

    // Pending-interrupt latch and one-cycle take strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_pend_r <= 1'b0;
            irq_take_r <= 1'b0;
        end else begin
            irq_take_r <= take_s;
            irq_pend_r <= take_s ? 1'b0 : (irq_pend_r || irq);
        end
    end
`else
    logic irq_unused_s;

    assign irq_unused_s = irq;
    assign stall_s      = 1'b0;
    assign irq_take     = 1'b0;
`endif

    // Request phase, timeout detection and request-field hold (first cycle passes inputs through).
    always_comb begin
        req_phase_s = 1'b0;
        addr_s      = addr_r;
        we_s        = we_r;
        wdata_s     = wdata_r;
        if (((state_r == FETCH) && !stall_s) || (state_r == MEM)) begin
            req_phase_s = 1'b1;
        end else begin
            req_phase_s = 1'b0;
        end
        first_s = (tmo_r == CW'(0));
        if (first_s) begin
            if (state_r == MEM) begin
                addr_s = data_addr;
                we_s   = mwr;
            end else begin
                addr_s = inst_addr;
                we_s   = 1'b0;
            end
            wdata_s = wdata;
        end else begin
            addr_s  = addr_r;
            we_s    = we_r;
            wdata_s = wdata_r;
        end
        wait_s    = req_phase_s && !mem_ack;
        tmo_hit_s = wait_s && (tmo_r == CW'(TIMEOUT_CYC - 1));
    end

    // Next-state logic; an ack in the timeout cycle takes priority over the timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            FETCH: begin
                if (req_phase_s && mem_ack) begin
                    state_s = EXEC;
                end else if (tmo_hit_s) begin
                    state_s = HALT;
                end else begin
                    state_s = FETCH;
                end
            end
            EXEC: begin
                if (moe || mwr) begin
                    state_s = MEM;
                end else begin
                    state_s = COMMIT;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    state_s = COMMIT;
                end else if (tmo_hit_s) begin
                    state_s = HALT;
                end else begin
                    state_s = MEM;
                end
            end
            COMMIT:  state_s = FETCH;
            HALT:    state_s = HALT;
            default: state_s = FETCH;
        endcase
    end

    // Output decode, forced quiet while reset is high so an abandoned request drops at once.
    always_comb begin
        mem_req   = req_phase_s && !reset;
        mem_we    = we_s && req_phase_s && !reset;
        mem_addr  = addr_s;
        mem_wdata = wdata_s;
        pc_en     = (state_r == COMMIT) && !reset;
        rf_we_en  = (state_r == COMMIT) && !reset;
        bus_err   = tmo_hit_s && !reset;
        halted    = (state_r == HALT) && !reset;
    end

    assign inst  = inst_r;
    assign ldata = ldata_r;

    // State, timeout counter, held request fields and capture registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
            tmo_r   <= CW'(0);
            addr_r  <= 32'd0;
            we_r    <= 1'b0;
            wdata_r <= 32'd0;
            inst_r  <= 32'd0;
            ldata_r <= 32'd0;
        end else begin
            state_r <= state_s;
            tmo_r   <= wait_s ? (tmo_r + CW'(1)) : CW'(0);
            if (req_phase_s && first_s) begin
                addr_r  <= addr_s;
                we_r    <= we_s;
                wdata_r <= wdata_s;
            end
            if ((state_r == FETCH) && req_phase_s && mem_ack) begin
                inst_r <= mem_rdata;
            end
            if ((state_r == MEM) && mem_ack && moe) begin
                ldata_r <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_beta_mem_sequencer.sv
// Scoreboard bench for beta_mem_sequencer: randomized instructions, memory latencies and irq pulses.
module tb_beta_mem_sequencer;
    localparam int TMO = 16;
    localparam int KREQ = 0, KCMT = 1, KIRQ = 2, KBUS = 3;

    logic        clk = 1'b0;
    logic        reset, irq, moe, mwr, mem_ack;
    logic [31:0] inst_addr, data_addr, wdata, mem_rdata;
    logic        mem_req, mem_we, pc_en, rf_we_en, irq_take, bus_err, halted;
    logic [31:0] mem_addr, mem_wdata, inst, ldata;

    beta_mem_sequencer #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .irq(irq), .moe(moe), .mwr(mwr),
        .inst_addr(inst_addr), .data_addr(data_addr), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .inst(inst), .ldata(ldata),
        .pc_en(pc_en), .rf_we_en(rf_we_en), .irq_take(irq_take), .bus_err(bus_err),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] inst;
        logic [31:0] ldata;
        int          lat;
    } exp_t;
    typedef struct {
        int          dly;
        logic [31:0] rdata;
    } ack_t;

    exp_t        sb_q[$];
    ack_t        ack_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_ldata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic get(output exp_t e, input int k, output bit ok);
        n_cmp++;
        ok = 1'b0;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_kind: got event %0d expected none at %0t", k, $time);
        end else if (sb_q[0].kind != k) begin
            n_err++;
            $display("FAIL sb_kind: got event %0d expected %0d at %0t", k, sb_q[0].kind, $time);
            void'(sb_q.pop_front());
        end else begin
            e  = sb_q.pop_front();
            ok = 1'b1;
        end
    endtask

    function automatic void push_exp(input int k, input logic [31:0] a, input logic w,
                                     input logic [31:0] wd, input logic [31:0] ins,
                                     input logic [31:0] ld, input int lat);
        exp_t e;
        e = '{kind: k, addr: a, we: w, wdata: wd, inst: ins, ldata: ld, lat: lat};
        sb_q.push_back(e);
    endfunction

    // Memory responder: acks a request after its scheduled number of wait cycles.
    bit          r_active = 1'b0;
    int          r_cnt, r_dly;
    logic [31:0] r_data;
    always begin
        @(negedge clk); #2;
        if (reset || !mem_req) r_active = 1'b0;
        if (!reset && mem_req && !r_active && ack_q.size() != 0) begin
            ack_t a;
            a = ack_q.pop_front();
            r_active = 1'b1; r_cnt = 0; r_dly = a.dly; r_data = a.rdata;
        end
        if (r_active) begin
            mem_ack   = (r_cnt >= r_dly);
            mem_rdata = mem_ack ? r_data : $urandom;
            r_cnt++;
        end else begin
            mem_ack   = (!reset && mem_req) ? 1'b0 : 1'($urandom % 2);
            mem_rdata = $urandom;
        end
    end

    // Monitor: observes each cycle after inputs settle and checks against the scoreboard.
    int          cyc = 0, st = 0, last_ack = 0, last_cmt = -10;
    bit          in_req = 1'b0, prev_rst = 1'b1, ok;
    logic [31:0] a0, w0;
    logic        we0;
    exp_t        e;
    always begin
        @(negedge clk); #3;
        cyc++;
        if (reset) begin
            chk("rst_outputs", 32'({mem_req, mem_we, pc_en, rf_we_en, irq_take, bus_err, halted}), 32'd0);
            in_req = 1'b0; prev_rst = 1'b1;
        end else begin
            if (prev_rst) chk("fetch_after_reset", 32'(mem_req), 32'd1);
            prev_rst = 1'b0;
            if (mem_req) begin
                if (!in_req) begin
                    in_req = 1'b1; st = cyc; a0 = mem_addr; we0 = mem_we; w0 = mem_wdata;
                end else begin
                    chk("hold_addr", mem_addr, a0);
                    chk("hold_we", 32'(mem_we), 32'(we0));
                    chk("hold_wdata", mem_wdata, w0);
                end
                if (mem_ack) begin
                    get(e, KREQ, ok);
                    if (ok) begin
                        chk("req_addr", mem_addr, e.addr);
                        chk("req_we", 32'(mem_we), 32'(e.we));
                        if (e.we) chk("req_wdata", mem_wdata, e.wdata);
                        chk("req_wait", 32'(cyc - st), 32'(e.lat));
                    end
                    last_ack = cyc; in_req = 1'b0;
                end else if (bus_err) begin
                    get(e, KBUS, ok);
                    if (ok) chk("buserr_wait", 32'(cyc - st), 32'(e.lat));
                    in_req = 1'b0;
                end
            end else begin
                in_req = 1'b0;
                if (bus_err) chk("buserr_noreq", 32'(bus_err), 32'd0);
            end
            if (pc_en) begin
                get(e, KCMT, ok);
                chk("rf_we_en", 32'(rf_we_en), 32'd1);
                if (ok) begin
                    chk("inst", inst, e.inst);
                    chk("ldata", ldata, e.ldata);
                    chk("commit_lat", 32'(cyc - last_ack), 32'(e.lat));
                end
                last_cmt = cyc;
            end else if (rf_we_en) begin
                chk("rf_we_alone", 32'(rf_we_en), 32'd0);
            end
            if (irq_take) begin
                get(e, KIRQ, ok);
                chk("irq_after_commit", 32'(cyc - last_cmt), 32'd1);
                chk("irq_noreq", 32'(mem_req), 32'd0);
            end
            if (halted) chk("halt_noreq", 32'({mem_req, pc_en}), 32'd0);
        end
    end

    // kind: 0 = ALU, 1 = load, 2 = store; mode: 0 = no irq, 1 = irq at start, 2 = irq during commit.
    task automatic run_txn(input int kind, input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wd, input logic [31:0] fr, input logic [31:0] mr,
                           input int fd, input int md, input int mode, output bit hl);
        inst_addr = ia; data_addr = da; wdata = wd;
        moe = (kind == 1); mwr = (kind == 2);
        ack_q.push_back('{fd, fr});
        if (fd >= TMO) begin
            push_exp(KBUS, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, TMO - 1);
        end else begin
            push_exp(KREQ, ia, 1'b0, 32'd0, 32'd0, 32'd0, fd);
            if (kind != 0) begin
                ack_q.push_back('{md, mr});
                if (md >= TMO) begin
                    push_exp(KBUS, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, TMO - 1);
                end else begin
                    push_exp(KREQ, da, kind == 2, wd, 32'd0, 32'd0, md);
                    if (kind == 1) model_ldata = mr;
                end
            end
            if (kind == 0 || md < TMO) begin
                push_exp(KCMT, 32'd0, 1'b0, 32'd0, fr, model_ldata, (kind != 0) ? 1 : 2);
`ifdef BETA_SEQ_IRQ_EN
                if (mode != 0) push_exp(KIRQ, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 0);
`endif
            end
        end
        hl = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            irq = (c == 0 && mode == 1);
            if (pc_en) begin
                if (mode == 2) irq = 1'b1;
                return;
            end
            if (halted) begin
                hl = 1'b1;
                return;
            end
        end
        n_cmp++; n_err++;
        $display("FAIL txn_timeout: got no commit or halt expected one within 200 cycles");
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset = 1'b1; irq = 1'b0;
        repeat (2) begin @(negedge clk); #1; end
        chk("rst_inst", inst, 32'd0);
        chk("rst_ldata", ldata, 32'd0);
        sb_q.delete(); ack_q.delete(); model_ldata = 32'd0;
        reset = 1'b0;
    endtask

    task automatic after_halt();
        repeat (3) begin @(negedge clk); #1; end
        chk("halted", 32'(halted), 32'd1);
        chk("sb_empty_at_halt", 32'(sb_q.size()), 32'd0);
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hl;
        int kind, fd, md, mode;
        reset = 1'b1; irq = 1'b0; moe = 1'b0; mwr = 1'b0;
        inst_addr = 32'd0; data_addr = 32'd0; wdata = 32'd0;
        repeat (3) begin @(negedge clk); #1; end
        chk("rst_inst", inst, 32'd0);
        chk("rst_ldata", ldata, 32'd0);
        reset = 1'b0;
        // Directed: ALU zero-wait, delayed load, store, timeout-boundary load, fetch timeout.
        run_txn(0, 32'h10, 32'h0, 32'h0, 32'h0000_1234, 32'h0, 0, 0, 0, hl);
        run_txn(1, 32'h14, 32'h40, 32'h0, 32'h0A00_0040, 32'hDEAD_BEEF, 0, 3, 0, hl);
        run_txn(2, 32'h18, 32'h80, 32'h1234_5678, 32'h0B00_0080, 32'h0, 1, 0, 0, hl);
        run_txn(1, 32'h1C, 32'h44, 32'h0, 32'h0A00_0044, 32'hCAFE_F00D, 0, TMO - 1, 0, hl);
        run_txn(0, 32'h20, 32'h0, 32'h0, 32'h0, 32'h0, TMO, 0, 0, hl);
        if (hl) after_halt();
        else begin n_cmp++; n_err++; $display("FAIL fetch_timeout: got no halt expected halt"); end
        // Reset while a load is waiting in MEM: request abandoned, no commit.
        inst_addr = 32'h24; data_addr = 32'h48; moe = 1'b1; mwr = 1'b0;
        ack_q.push_back('{0, 32'h0A00_0048});
        ack_q.push_back('{255, 32'h0});
        push_exp(KREQ, 32'h24, 1'b0, 32'd0, 32'd0, 32'd0, 0);
        repeat (5) begin @(negedge clk); #1; end
        chk("mem_wait_req", 32'({mem_req, mem_we}), 32'b10);
        do_reset();
        run_txn(0, 32'h100, 32'h0, 32'h0, 32'h0000_5555, 32'h0, 0, 0, 0, hl);
        // Interrupts: pulse during a delayed load, then during commit.
        run_txn(1, 32'h104, 32'h50, 32'h0, 32'h0A00_0050, 32'h7777_0001, 2, 2, 1, hl);
        run_txn(0, 32'h108, 32'h0, 32'h0, 32'h0000_6666, 32'h0, 1, 0, 2, hl);
        run_txn(0, 32'h10C, 32'h0, 32'h0, 32'h0000_6667, 32'h0, 0, 0, 0, hl);
        // Random instructions, latencies and interrupts.
        for (int i = 0; i < 60; i++) begin
            int r;
            kind = $urandom_range(0, 2);
            mode = $urandom_range(0, 2);
            r = $urandom_range(0, 19);
            fd = (r < 14) ? r % 4 : (r < 17) ? $urandom_range(4, 8) : (r == 17) ? TMO - 1 : TMO;
            r = $urandom_range(0, 19);
            md = (r < 14) ? r % 4 : (r < 17) ? $urandom_range(4, 8) : (r == 17) ? TMO - 1 : TMO;
            run_txn(kind, $urandom, $urandom, $urandom, $urandom, $urandom, fd, md, mode, hl);
            if (hl) after_halt();
        end
        repeat (2) begin @(negedge clk); #1; end
        irq = 1'b0;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/beta_mem_sequencer.md
BETA_MEM_SEQUENCER -- requirements
Module: beta_mem_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter TIMEOUT_CYC SHALL default to 16 and set the maximum number of cycles mem_req may wait for mem_ack.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 irq  in  1  level interrupt request.
REQ-006 moe, mwr  in  1 each  decoded memory read/write enables for the current instruction.
REQ-007 inst_addr, data_addr, wdata  in  32 each  PC, ALU result, store data.
REQ-008 mem_req, mem_we  out  1 each  memory request and write strobe.
REQ-009 mem_addr, mem_wdata  out  32 each  memory address and write data.
REQ-010 mem_ack  in  1; mem_rdata  in  32  memory handshake and read data.
REQ-011 inst, ldata  out  32 each  instruction register and load-data register.
REQ-012 pc_en, rf_we_en, irq_take, bus_err  out  1 each  commit strobes, interrupt-taken strobe, timeout strobe.
REQ-013 halted  out  1  sequencer stopped after a bus error.

Function
REQ-014 The FSM SHALL have five states: FETCH, EXEC, MEM, COMMIT, HALT.
REQ-015 FETCH SHALL drive mem_req=1, mem_we=0 and mem_addr=inst_addr, and on mem_ack SHALL capture mem_rdata into inst and go to EXEC.
REQ-016 EXEC SHALL last one cycle and go to MEM if moe|mwr, else to COMMIT.
REQ-017 MEM SHALL drive mem_req=1, mem_we=mwr, mem_addr=data_addr and mem_wdata=wdata; on mem_ack it SHALL capture mem_rdata into ldata when moe=1 and go to COMMIT.
REQ-018 COMMIT SHALL pulse pc_en=1 and rf_we_en=1 for exactly one cycle, then go to FETCH.
REQ-019 mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable while mem_req=1 and mem_ack=0.
REQ-020 mem_ack MAY be high in the first cycle of a request and SHALL be ignored while mem_req=0.
REQ-021 With zero-wait memory, a non-memory instruction SHALL take 3 cycles and a load or store SHALL take 4 cycles.
REQ-022 A timeout counter SHALL clear on entry to FETCH or MEM and increment each waiting cycle.
REQ-023 If no mem_ack arrives within TIMEOUT_CYC cycles of request start, the block SHALL pulse bus_err for one cycle, suppress pc_en/rf_we_en, and enter HALT.
REQ-024 HALT SHALL hold mem_req=0 and halted=1 until reset.
REQ-025 When mem_ack arrives in the same cycle the timeout is reached, the ack SHALL win and no bus_err SHALL be raised.
REQ-026 irq high in any clk cycle SHALL set irq_pend.
REQ-027 On the transition COMMIT->FETCH with irq_pend=1, the block SHALL instead spend one cycle with irq_take=1 and mem_req=0, clear irq_pend, then go to FETCH.
REQ-028 irq arriving during COMMIT SHALL be taken at the same COMMIT exit.
REQ-029 irq_pend SHALL NOT interrupt an outstanding FETCH or MEM request.

Reset
REQ-030 While reset=1, mem_req, mem_we, pc_en, rf_we_en, irq_take, bus_err and halted SHALL be 0.
REQ-031 Reset SHALL load state=FETCH, inst=0, ldata=0, irq_pend=0 and the timeout counter=0.
REQ-032 Reset asserted mid-FETCH or mid-MEM SHALL abandon the request with no commit strobe and restart with FETCH in the first cycle after reset drops.
REQ-033 Reset SHALL exit HALT.

Configuration
REQ-034 With BETA_SEQ_IRQ_EN defined, interrupt logic SHALL behave per REQ-026..REQ-029.
REQ-035 Without BETA_SEQ_IRQ_EN, irq SHALL be ignored, irq_take SHALL be tied to 0, and no irq_pend register SHALL exist.

Verification
REQ-036 Zero-wait ADD, inst_addr=0x10, mem_ack tied high -> pc_en pulses exactly once, 3 cycles after reset release; inst=fetched word.
REQ-037 LD, data_addr=0x40, mem_rdata=0xDEADBEEF, ack delayed 3 cycles -> address and controls held steady through the wait; ldata=0xDEADBEEF; rf_we_en single pulse.
REQ-038 ST, wdata=0x12345678, mwr=1 -> MEM cycle shows mem_we=1, mem_addr=data_addr, mem_wdata=0x12345678; exactly one write.
REQ-039 mem_ack never asserted during FETCH, TIMEOUT_CYC=16 -> bus_err pulses one cycle at the 16th wait cycle; halted=1; mem_req=0 thereafter; no pc_en.
REQ-040 One-cycle irq pulse during MEM -> instruction completes; irq_take=1 for one cycle after COMMIT; next FETCH follows. With BETA_SEQ_IRQ_EN undefined -> irq_take never asserts.
REQ-041 Reset asserted during a waiting MEM request -> mem_req=0 that cycle; no commit strobe; FETCH of inst_addr in the first cycle after release.
